ecc_point_seq: RTL and testbench

Affine elliptic-curve point sequencer sitting directly upstream of the GFAU. It latches two points, curve coefficient `a` and prime `p`. It then issues a fixed microcoded sequence of field operations (add, sub, mult, div) to the GFAU one at a time and assembles R = P + Q or R = 2P. Special cases produce the point at infinity without any GFAU traffic.

---
 rtl/ecc_point_seq.sv | 210 +++++++++++++++++++++
 tb/tb_ecc_point_seq.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_point_seq.sv
// Affine elliptic-curve point sequencer: runs a microcoded P+Q or 2P program on an external GFAU,
// one field operation at a time. Infinity cases are resolved in IDLE with no GFAU traffic.
module ecc_point_seq #(
  parameter int unsigned SIZE = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            start,
  input  logic            mode,
  input  logic [SIZE-1:0] x1,
  input  logic [SIZE-1:0] y1,
  input  logic [SIZE-1:0] x2,
  input  logic [SIZE-1:0] y2,
  input  logic [SIZE-1:0] a_coef,
  input  logic [SIZE-1:0] prime,
  output logic [SIZE-1:0] x3,
  output logic [SIZE-1:0] y3,
  output logic            out_inf,
  output logic            done,
  output logic            busy,
  output logic [SIZE-1:0] gf_in_0,
  output logic [SIZE-1:0] gf_in_1,
  output logic [SIZE-1:0] gf_prime,
  output logic [1:0]      gf_op,
  output logic            gf_start,
  input  logic [SIZE-1:0] gf_result,
  input  logic            gf_done
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFin} state_e;

  localparam int unsigned NumRegs = 12;

  localparam logic [3:0] RegX1 = 4'd0;
  localparam logic [3:0] RegY1 = 4'd1;
  localparam logic [3:0] RegX2 = 4'd2;
  localparam logic [3:0] RegY2 = 4'd3;
  localparam logic [3:0] RegA  = 4'd4;
  localparam logic [3:0] RegT0 = 4'd5;
  localparam logic [3:0] RegT1 = 4'd6;
  localparam logic [3:0] RegT2 = 4'd7;
  localparam logic [3:0] RegT3 = 4'd8;
  localparam logic [3:0] RegL  = 4'd9;
  localparam logic [3:0] RegX3 = 4'd10;
  localparam logic [3:0] RegY3 = 4'd11;

  localparam logic [1:0] OpAdd = 2'd0;
  localparam logic [1:0] OpSub = 2'd1;
  localparam logic [1:0] OpMul = 2'd2;
  localparam logic [1:0] OpDiv = 2'd3;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst;
    logic       last;
  } uop_t;

  function automatic uop_t mk(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] d, input logic l);
    uop_t u;
    u.op    = op;
    u.src_a = a;
    u.src_b = b;
    u.dst   = d;
    u.last  = l;
    return u;
  endfunction

  // Index is {double_program, step}.
  function automatic uop_t rom_entry(input logic dbl, input logic [3:0] step);
    uop_t u;
    case ({dbl, step})
      5'h00:   u = mk(OpSub, RegY2, RegY1, RegT0, 1'b0);
      5'h01:   u = mk(OpSub, RegX2, RegX1, RegT1, 1'b0);
      5'h02:   u = mk(OpDiv, RegT0, RegT1, RegL,  1'b0);
      5'h03:   u = mk(OpMul, RegL,  RegL,  RegT2, 1'b0);
      5'h04:   u = mk(OpSub, RegT2, RegX1, RegT2, 1'b0);
      5'h05:   u = mk(OpSub, RegT2, RegX2, RegX3, 1'b0);
      5'h06:   u = mk(OpSub, RegX1, RegX3, RegT3, 1'b0);
      5'h07:   u = mk(OpMul, RegL,  RegT3, RegT3, 1'b0);
      5'h08:   u = mk(OpSub, RegT3, RegY1, RegY3, 1'b1);
      5'h10:   u = mk(OpMul, RegX1, RegX1, RegT0, 1'b0);
      5'h11:   u = mk(OpAdd, RegT0, RegT0, RegT1, 1'b0);
      5'h12:   u = mk(OpAdd, RegT1, RegT0, RegT1, 1'b0);
      5'h13:   u = mk(OpAdd, RegT1, RegA,  RegT1, 1'b0);
      5'h14:   u = mk(OpAdd, RegY1, RegY1, RegT2, 1'b0);
      5'h15:   u = mk(OpDiv, RegT1, RegT2, RegL,  1'b0);
      5'h16:   u = mk(OpMul, RegL,  RegL,  RegT2, 1'b0);
      5'h17:   u = mk(OpSub, RegT2, RegX1, RegT2, 1'b0);
      5'h18:   u = mk(OpSub, RegT2, RegX1, RegX3, 1'b0);
      5'h19:   u = mk(OpSub, RegX1, RegX3, RegT3, 1'b0);
      5'h1a:   u = mk(OpMul, RegL,  RegT3, RegT3, 1'b0);
      5'h1b:   u = mk(OpSub, RegT3, RegY1, RegY3, 1'b1);
      default: u = '0;
    endcase
    return u;
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      step_q, step_d;
  logic            dbl_q, dbl_d;
  logic [SIZE-1:0] rf_q [NumRegs];
  logic [SIZE-1:0] rf_d [NumRegs];
  logic [SIZE-1:0] x3_q, x3_d, y3_q, y3_d, prime_q, prime_d;
  logic            inf_q, inf_d;
  uop_t            uop;

  assign uop = rom_entry(dbl_q, step_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      step_q  <= '0;
      dbl_q   <= 1'b0;
      rf_q    <= '{default: '0};
      x3_q    <= '0;
      y3_q    <= '0;
      inf_q   <= 1'b0;
      prime_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dbl_q   <= dbl_d;
      rf_q    <= rf_d;
      x3_q    <= x3_d;
      y3_q    <= y3_d;
      inf_q   <= inf_d;
      prime_q <= prime_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    dbl_d    = dbl_q;
    rf_d     = rf_q;
    x3_d     = x3_q;
    y3_d     = y3_q;
    inf_d    = inf_q;
    prime_d  = prime_q;
    gf_start = 1'b0;
    gf_op    = '0;
    gf_in_0  = '0;
    gf_in_1  = '0;
    done     = 1'b0;
    busy     = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rf_d[RegX1] = x1;
          rf_d[RegY1] = y1;
          rf_d[RegX2] = x2;
          rf_d[RegY2] = y2;
          rf_d[RegA]  = a_coef;
          prime_d     = prime;
          step_d      = '0;
          if (mode ? (y1 == '0) : (x1 == x2 && y1 != y2)) begin
            inf_d   = 1'b1;
            x3_d    = '0;
            y3_d    = '0;
            state_d = StFin;
          end else begin
            // mode 0 reaching here with x1 == x2 means P == Q.
            dbl_d   = mode | (x1 == x2);
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        gf_start = 1'b1;
        gf_op    = uop.op;
        gf_in_0  = rf_q[uop.src_a];
        gf_in_1  = rf_q[uop.src_b];
        state_d  = StWait;
      end
      StWait: begin
        gf_op   = uop.op;
        gf_in_0 = rf_q[uop.src_a];
        gf_in_1 = rf_q[uop.src_b];
        if (gf_done) begin
          rf_d[uop.dst] = gf_result;
          if (uop.last) begin
            // Both programs end by writing Y3; X3 was written several steps earlier.
            x3_d    = rf_q[RegX3];
            y3_d    = gf_result;
            inf_d   = 1'b0;
            state_d = StFin;
          end else begin
            step_d  = step_q + 4'd1;
            state_d = StIssue;
          end
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign x3       = x3_q;
  assign y3       = y3_q;
  assign out_inf  = inf_q;
  assign gf_prime = prime_q;

endmodule

// File: tb/tb_ecc_point_seq.sv
// Self-checking bench for ecc_point_seq: ideal mod-p GFAU model with configurable latency and a
// point-arithmetic reference model over y^2 = x^3 + 2x + 3 (mod 97).
module tb_ecc_point_seq;

  localparam longint P = 97;
  localparam longint A = 2;

  logic        clk = 1'b0;
  logic        rst, start, mode;
  logic [31:0] x1, y1, x2, y2, a_coef, prime;
  logic [31:0] x3, y3, gf_in_0, gf_in_1, gf_prime, gf_result;
  logic        out_inf, done, busy, gf_start, gf_done;
  logic [1:0]  gf_op;

  int n_tests = 0;
  int n_fail  = 0;

  // GFAU model state (written only by the model process)
  int     lat_fixed = 3;
  int     op_q[$];
  int     lat_q[$];
  int     stab_bad = 0;
  int     spur_req = 0;
  int     spur_seen = 0;
  longint ga, gb, gr;
  int     gop, gn;

  int exp_add_ops [9]  = '{1, 1, 3, 2, 1, 1, 1, 2, 1};
  int exp_dbl_ops [12] = '{2, 0, 0, 0, 0, 3, 2, 1, 1, 1, 2, 1};

  always #5 clk = ~clk;

  ecc_point_seq #(.SIZE(32)) dut (
    .i_clk(clk), .i_rst(rst), .start(start), .mode(mode),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .a_coef(a_coef), .prime(prime),
    .x3(x3), .y3(y3), .out_inf(out_inf), .done(done), .busy(busy),
    .gf_in_0(gf_in_0), .gf_in_1(gf_in_1), .gf_prime(gf_prime), .gf_op(gf_op),
    .gf_start(gf_start), .gf_result(gf_result), .gf_done(gf_done)
  );

  function automatic longint md(input longint v);
    return ((v % P) + P) % P;
  endfunction

  function automatic longint pw(input longint b, input longint e);
    longint r = 1;
    longint bb = md(b);
    longint ee = e;
    while (ee > 0) begin
      if (ee[0]) r = (r * bb) % P;
      bb = (bb * bb) % P;
      ee = ee >> 1;
    end
    return r;
  endfunction

  function automatic longint inv(input longint b);
    return pw(b, P - 2);
  endfunction

  // Reference point arithmetic, straight from the group-law formulas.
  task automatic ec_ref(input bit m, input longint ax1, input longint ay1, input longint ax2,
                        input longint ay2, output bit inf, output longint rx, output longint ry);
    longint lam;
    bit     dbl;
    inf = 1'b0;
    rx  = 0;
    ry  = 0;
    dbl = m || (ax1 == ax2);
    if (m ? (ay1 == 0) : (ax1 == ax2 && ay1 != ay2)) begin
      inf = 1'b1;
    end else begin
      if (dbl) lam = md(md(3 * ax1 * ax1 + A) * inv(md(2 * ay1)));
      else     lam = md(md(ay2 - ay1) * inv(md(ax2 - ax1)));
      rx = md(lam * lam - ax1 - (dbl ? ax1 : ax2));
      ry = md(lam * md(ax1 - rx) - ay1);
    end
  endtask

  // GFAU model: N cycles from the issue cycle to the gf_done cycle.
  initial begin
    gf_done   = 1'b0;
    gf_result = '0;
    forever begin
      @(negedge clk);
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        @(posedge clk); #1;
        gf_done   = 1'b1;
        gf_result = $urandom;
        @(posedge clk); #1;
        gf_done = 1'b0;
      end else if (gf_start === 1'b1) begin
        ga  = longint'(gf_in_0);
        gb  = longint'(gf_in_1);
        gop = int'(gf_op);
        gn  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(40, 1));
        op_q.push_back(gop);
        lat_q.push_back(gn);
        case (gop)
          0:       gr = md(ga + gb);
          1:       gr = md(ga - gb);
          2:       gr = md(ga * gb);
          default: gr = md(ga * inv(gb));
        endcase
        for (int i = 1; i <= gn; i++) begin
          @(posedge clk); #1;
          if (i == gn) begin
            gf_done   = 1'b1;
            gf_result = 32'(gr);
          end
          @(negedge clk);
          if (busy === 1'b1 && (longint'(gf_in_0) != ga || longint'(gf_in_1) != gb ||
                                int'(gf_op) != gop))
            stab_bad++;
        end
        @(posedge clk); #1;
        gf_done = 1'b0;
      end
    end
  end

  // One request; returns the done cycle relative to the accept cycle (0).
  task automatic run_op(input bit m, input longint px1, input longint py1, input longint px2,
                        input longint py2, input bit noise, output int dc);
    bit got = 1'b0;
    bit busy_bad = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = m;
    x1 = 32'(px1); y1 = 32'(py1); x2 = 32'(px2); y2 = 32'(py2);
    a_coef = 32'(A); prime = 32'(P);
    @(negedge clk);
    if (busy !== 1'b0) busy_bad = 1'b1;
    dc = 0;
    while (!got && dc < 4000) begin
      @(posedge clk); #1;
      dc++;
      if (noise) begin
        start = 1'($urandom_range(1, 0));
        mode  = 1'($urandom_range(1, 0));
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
        a_coef = $urandom; prime = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy !== 1'b1 || gf_prime !== 32'(P)) busy_bad = 1'b1;
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout: no done after %0d cycles, required done", dc);
    end
    n_tests++;
    if (busy_bad) begin
      n_fail++;
      $display("FAIL busy_window: busy/gf_prime wrong during op, required busy=1 prime=%0d", P);
    end
  endtask

  task automatic check_ops(input string name, input int base, input bit dbl);
    int n   = dbl ? 12 : 9;
    int bad = -1;
    n_tests++;
    if (op_q.size() != base + n) begin
      n_fail++;
      $display("FAIL %s_op_count: got %0d gf_start pulses, required %0d", name,
               op_q.size() - base, n);
    end else begin
      for (int i = 0; i < n; i++)
        if (bad < 0 && op_q[base + i] != (dbl ? exp_dbl_ops[i] : exp_add_ops[i])) bad = i;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s_op_seq: step %0d op %0d, required %0d", name, bad, op_q[base + bad],
                 dbl ? exp_dbl_ops[bad] : exp_add_ops[bad]);
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_tests++;
    if (x3 !== 0 || y3 !== 0 || out_inf !== 0 || done !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: x3=%0d y3=%0d inf=%b done=%b busy=%b, required all 0",
               x3, y3, out_inf, done, busy);
    end
    n_tests++;
    if (gf_start !== 0 || gf_op !== 0 || gf_in_0 !== 0 || gf_in_1 !== 0 || gf_prime !== 0) begin
      n_fail++;
      $display("FAIL reset_gf: start=%b op=%0d in0=%0d in1=%0d prime=%0d, required all 0",
               gf_start, gf_op, gf_in_0, gf_in_1, gf_prime);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 0 || done !== 0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_double_fixed;
    int dc;
    int base = op_q.size();
    lat_fixed = 3;
    run_op(1'b1, 3, 6, 0, 0, 1'b0, dc);
    n_tests++;
    if (dc != 49) begin
      n_fail++;
      $display("FAIL double_latency: done cycle %0d, required 49", dc);
    end
    n_tests++;
    if (x3 !== 32'd80 || y3 !== 32'd10 || out_inf !== 1'b0) begin
      n_fail++;
      $display("FAIL double_result: (%0d,%0d) inf=%b, required (80,10) inf=0", x3, y3, out_inf);
    end
    check_ops("double", base, 1'b1);
  endtask

  task automatic test_add_fixed;
    int dc;
    int base = op_q.size();
    lat_fixed = 3;
    run_op(1'b0, 3, 6, 80, 10, 1'b0, dc);
    n_tests++;
    if (dc != 37) begin
      n_fail++;
      $display("FAIL add_latency: done cycle %0d, required 37", dc);
    end
    n_tests++;
    if (x3 !== 32'd80 || y3 !== 32'd87 || out_inf !== 1'b0) begin
      n_fail++;
      $display("FAIL add_result: (%0d,%0d) inf=%b, required (80,87) inf=0", x3, y3, out_inf);
    end
    check_ops("add", base, 1'b0);
  endtask

  task automatic test_infinity;
    int dc;
    int base;
    for (int k = 0; k < 2; k++) begin
      base = op_q.size();
      if (k == 0) run_op(1'b0, 3, 6, 3, 91, 1'b0, dc);
      else        run_op(1'b1, 5, 0, 7, 9, 1'b0, dc);
      n_tests++;
      if (dc != 1 || out_inf !== 1'b1 || x3 !== 0 || y3 !== 0) begin
        n_fail++;
        $display("FAIL infinity_%0d: cycle=%0d inf=%b (%0d,%0d), required cycle 1 inf=1 (0,0)",
                 k, dc, out_inf, x3, y3);
      end
      n_tests++;
      if (op_q.size() != base) begin
        n_fail++;
        $display("FAIL infinity_%0d_traffic: %0d gf_start pulses, required 0", k,
                 op_q.size() - base);
      end
      // Refill x3/y3 with a finite result so the second case checks clearing again.
      if (k == 0) run_op(1'b1, 3, 6, 0, 0, 1'b0, dc);
    end
  endtask

  task automatic check_random_run(input string name, input bit m, input longint px1,
                                  input longint py1, input longint px2, input longint py2,
                                  input bit noise);
    int     dc, exp_dc, base;
    bit     e_inf;
    longint ex, ey;
    base = op_q.size();
    ec_ref(m, px1, py1, px2, py2, e_inf, ex, ey);
    run_op(m, px1, py1, px2, py2, noise, dc);
    exp_dc = 1;
    for (int i = base; i < lat_q.size(); i++) exp_dc += lat_q[i] + 1;
    n_tests++;
    if (out_inf !== e_inf || x3 !== 32'(ex) || y3 !== 32'(ey)) begin
      n_fail++;
      $display("FAIL %s_result: m=%0d P=(%0d,%0d) Q=(%0d,%0d) got (%0d,%0d) inf=%b, required (%0d,%0d) inf=%b",
               name, m, px1, py1, px2, py2, x3, y3, out_inf, ex, ey, e_inf);
    end
    n_tests++;
    if (dc != exp_dc) begin
      n_fail++;
      $display("FAIL %s_latency: done cycle %0d, required %0d", name, dc, exp_dc);
    end
  endtask

  task automatic test_auto_double;
    int base = op_q.size();
    lat_fixed = 0;
    check_random_run("auto_double", 1'b0, 3, 6, 3, 6, 1'b1);
    check_ops("auto_double", base, 1'b1);
    n_tests++;
    if (x3 !== 32'd80 || y3 !== 32'd10) begin
      n_fail++;
      $display("FAIL auto_double_const: (%0d,%0d), required (80,10)", x3, y3);
    end
  endtask

  task automatic test_back_to_back;
    int dc;
    lat_fixed = 2;
    run_op(1'b0, 3, 6, 80, 10, 1'b0, dc);
    n_tests++;
    if (dc != 28) begin
      n_fail++;
      $display("FAIL b2b_first: done cycle %0d, required 28", dc);
    end
    run_op(1'b1, 3, 6, 0, 0, 1'b0, dc);
    n_tests++;
    if (dc != 37 || x3 !== 32'd80 || y3 !== 32'd10) begin
      n_fail++;
      $display("FAIL b2b_second: cycle %0d (%0d,%0d), required cycle 37 (80,10)", dc, x3, y3);
    end
  endtask

  task automatic test_random;
    longint rx1, ry1, rx2, ry2;
    bit     m;
    lat_fixed = 0;
    for (int k = 0; k < 8; k++) begin
      m   = 1'($urandom_range(1, 0));
      rx1 = $urandom_range(96, 0);
      ry1 = (k == 5) ? 0 : $urandom_range(96, 0);
      rx2 = (k % 3 == 0) ? rx1 : $urandom_range(96, 0);
      ry2 = (k % 3 == 0) ? ((k == 3) ? md(P - ry1) : ry1) : $urandom_range(96, 0);
      check_random_run("random", m, rx1, ry1, rx2, ry2, k[0]);
    end
  endtask

  task automatic test_reset_mid;
    int dc;
    lat_fixed = 3;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0;
    x1 = 3; y1 = 6; x2 = 80; y2 = 10; a_coef = 32'(A); prime = 32'(P);
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    // Cycle 22: step 5 (X3 = T2 - X2) is waiting on the GFAU.
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || gf_op !== 2'd1) begin
      n_fail++;
      $display("FAIL rst_pre: busy=%b op=%0d, required busy=1 op=1", busy, gf_op);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 0 || done !== 0 || gf_start !== 0 || x3 !== 0 || y3 !== 0 || out_inf !== 0 ||
        gf_in_0 !== 0 || gf_in_1 !== 0 || gf_op !== 0 || gf_prime !== 0) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%b done=%b gfs=%b x3=%0d y3=%0d in0=%0d prime=%0d, required all 0",
               busy, done, gf_start, x3, y3, gf_in_0, gf_prime);
    end
    for (int k = 0; k < 2; k++) begin
      if (k == 1) spur_req++;
      dc = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (busy !== 0 || done !== 0 || gf_start !== 0 || x3 !== 0) dc++;
      end
      n_tests++;
      if (dc != 0) begin
        n_fail++;
        $display("FAIL %s: %0d cycles left idle, required 0", k ? "spurious_done" : "stale_done",
                 dc);
      end
    end
    run_op(1'b1, 3, 6, 0, 0, 1'b0, dc);
    n_tests++;
    if (dc != 49 || x3 !== 32'd80 || y3 !== 32'd10 || out_inf !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_double: cycle %0d (%0d,%0d), required cycle 49 (80,10)", dc, x3,
               y3);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; a_coef = '0; prime = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_double_fixed();
    test_add_fixed();
    test_infinity();
    test_auto_double();
    test_back_to_back();
    test_random();
    test_reset_mid();
    n_tests++;
    if (stab_bad != 0) begin
      n_fail++;
      $display("FAIL operand_stability: %0d unstable WAIT cycles, required 0", stab_bad);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
